// File: rtl/bus_fifo_pkg.sv
// Shared widths, defaults and full-policy encodings for the per-driver FIFO bank.
// Defaults match the standard 4-driver, 16-bit, 8-deep bus configuration.
package bus_fifo_pkg;

  localparam int DEF_PCKG_SZ   = 16;
  localparam int DEF_DEEP_FIFO = 8;
  localparam int DEF_DRVRS     = 4;
  localparam int CNT_W         = $clog2(DEF_DEEP_FIFO + 1);

  // Full policy encodings for DROP_MODE.
  localparam int FIFO_REJECT    = 0;
  localparam int FIFO_OVERWRITE = 1;

  typedef logic [DEF_PCKG_SZ-1:0] word_t;
  typedef logic [CNT_W-1:0]       count_t;

endpackage

// File: rtl/fifo_channel.sv
// Single first-word-fall-through FIFO with occupancy status, selectable
// full policy and a sticky, set-dominant overflow flag.
module fifo_channel
  import bus_fifo_pkg::*;
#(
  parameter  int pckg_sz   = DEF_PCKG_SZ,
  parameter  int deep_fifo = DEF_DEEP_FIFO,
  parameter  int AF_TH     = deep_fifo - 2,
  parameter  int DROP_MODE = FIFO_REJECT,
  localparam int CW        = $clog2(deep_fifo + 1),
  localparam int PW        = $clog2(deep_fifo)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               pop,
  input  logic               clr_ovf,
  output logic [pckg_sz-1:0] D_pop,
  output logic               pndng,
  output logic               full,
  output logic               almost_full,
  output logic [CW-1:0]      count,
  output logic               ovf
);

  logic [pckg_sz-1:0] mem_q [deep_fifo];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               is_empty, is_full, do_pop, ovf_set, wr_en, rd_adv;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(deep_fifo - 1)) ? '0 : p + PW'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(deep_fifo));

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    do_pop   = pop && !is_empty;
    ovf_set  = push && is_full && !do_pop;
    wr_en    = push && (!is_full || do_pop || (DROP_MODE == FIFO_OVERWRITE));
    rd_adv   = do_pop || (ovf_set && (DROP_MODE == FIFO_OVERWRITE));
    rd_ptr_d = rd_adv ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = wr_en  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_adv)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_adv) count_d = count_q - CW'(1);
    ovf_d    = ovf_set || (ovf_q && !clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is not reset; D_pop is masked by count so stale words never leak.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= D_push;
  end

  assign D_pop       = is_empty ? '0 : mem_q[rd_ptr_q];
  assign pndng       = !is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= CW'(AF_TH));
  assign count       = count_q;
  assign ovf         = ovf_q;

endmodule

// File: rtl/bus_fifo_bank.sv
// Bank of independent FIFOs, one per bus driver, feeding the bus arbiter.
module bus_fifo_bank
  import bus_fifo_pkg::*;
#(
  parameter  int pckg_sz   = DEF_PCKG_SZ,
  parameter  int deep_fifo = DEF_DEEP_FIFO,
  parameter  int drvrs     = DEF_DRVRS,
  parameter  int AF_TH     = deep_fifo - 2,
  parameter  int DROP_MODE = FIFO_REJECT,
  localparam int CW        = $clog2(deep_fifo + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [drvrs-1:0]               push,
  input  logic [drvrs-1:0][pckg_sz-1:0]  D_push,
  input  logic [drvrs-1:0]               pop,
  output logic [drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [drvrs-1:0]               pndng,
  output logic [drvrs-1:0]               full,
  output logic [drvrs-1:0]               almost_full,
  output logic [drvrs-1:0][CW-1:0]       count,
  output logic [drvrs-1:0]               ovf,
  input  logic [drvrs-1:0]               clr_ovf
);

  for (genvar i = 0; i < drvrs; i++) begin : g_ch
    fifo_channel #(
      .pckg_sz  (pckg_sz),
      .deep_fifo(deep_fifo),
      .AF_TH    (AF_TH),
      .DROP_MODE(DROP_MODE)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push[i]),
      .D_push     (D_push[i]),
      .pop        (pop[i]),
      .clr_ovf    (clr_ovf[i]),
      .D_pop      (D_pop[i]),
      .pndng      (pndng[i]),
      .full       (full[i]),
      .almost_full(almost_full[i]),
      .count      (count[i]),
      .ovf        (ovf[i])
    );
  end

endmodule

// File: tb/tb_bus_fifo_bank.sv
// Directed bench for bus_fifo_bank: a reject-policy bank and an overwrite-policy
// bank share one stimulus stream; expected values are hand-computed.
module tb_bus_fifo_bank;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       push, pop, clr_ovf;
  logic [3:0][15:0] D_push;
  logic [3:0][15:0] D_pop, ow_D_pop;
  logic [3:0]       pndng, full, almost_full, ovf;
  logic [3:0]       ow_pndng, ow_full, ow_almost_full, ow_ovf;
  logic [3:0][3:0]  count, ow_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_fifo_bank #(.DROP_MODE(0)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .almost_full(almost_full),
    .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  bus_fifo_bank #(.DROP_MODE(1)) dut_ow (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(ow_D_pop), .pndng(ow_pndng), .full(ow_full), .almost_full(ow_almost_full),
    .count(ow_count), .ovf(ow_ovf), .clr_ovf(clr_ovf)
  );

  // Status record: {pndng, full, almost_full, ovf, count[3:0], D_pop[15:0]}.
  typedef struct {
    logic [3:0]  push, pop, clr;
    logic [15:0] din;
    int          ch;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] st(input logic p, f, a, o, input int cnt, input int d);
    return {p, f, a, o, 4'(cnt), 16'(d)};
  endfunction

  function automatic logic [23:0] st_of(input int ch);
    return {pndng[ch], full[ch], almost_full[ch], ovf[ch], count[ch], D_pop[ch]};
  endfunction

  function automatic logic [23:0] st_ow(input int ch);
    return {ow_pndng[ch], ow_full[ch], ow_almost_full[ch], ow_ovf[ch], ow_count[ch], ow_D_pop[ch]};
  endfunction

  function automatic vec_t mk(input logic [3:0] pu, po, cl, input int d, input int ch,
                              input logic [23:0] e);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.din = 16'(d); v.ch = ch; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] pu, po, cl, input int d);
    @(negedge clk);
    push = pu; pop = po; clr_ovf = cl; D_push = {4{16'(d)}};
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single-cycle vectors: one channel's status checked after each edge.
    vecs.push_back(mk(4'h1, 4'h0, 4'h0, 20, 0, st(1, 0, 0, 0, 1, 20)));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0,  1, st(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0,  0, st(0, 0, 0, 0, 0, 0)));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(4'h2, 4'h0, 4'h0, k, 1, st(1, k == 8, k >= 6, 0, k, 1)));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 1,
                        st(j < 8, 0, (8 - j) >= 6, 0, 8 - j, (j < 8) ? j + 1 : 0)));
    vecs.push_back(mk(4'h8, 4'h0, 4'h0, 10, 3, st(1, 0, 0, 0, 1, 10)));
    vecs.push_back(mk(4'h8, 4'h0, 4'h0, 20, 3, st(1, 0, 0, 0, 2, 10)));
    vecs.push_back(mk(4'h8, 4'h8, 4'h0, 30, 3, st(1, 0, 0, 0, 2, 20)));
    vecs.push_back(mk(4'h1, 4'h1, 4'h0, 5,  0, st(1, 0, 0, 0, 1, 5)));
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0,  0, st(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0,  0, st(0, 0, 0, 0, 0, 0)));
    for (int k = 3; k <= 8; k++)
      vecs.push_back(mk(4'h8, 4'h0, 4'h0, 10 * (k + 1), 3, st(1, k == 8, k >= 6, 0, k, 20)));
    vecs.push_back(mk(4'h8, 4'h0, 4'h8, 99, 3, st(1, 1, 1, 1, 8, 20)));
    vecs.push_back(mk(4'h0, 4'h0, 4'h8, 0,  3, st(1, 1, 1, 0, 8, 20)));

    reset = 1'b1; push = '0; pop = '0; clr_ovf = '0; D_push = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dpop",   64'(D_pop), 64'h0);
    check("reset_status", 64'({pndng, full, almost_full, ovf, count}), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].clr, 32'(vecs[i].din));
      check($sformatf("vec%0d_ch%0d", i, vecs[i].ch), 64'(st_of(vecs[i].ch)), 64'(vecs[i].exp));
    end

    // Full policy on ch2: reject keeps 1..8, overwrite drops 1 and keeps 99.
    for (int k = 1; k <= 8; k++) drive(4'h4, 4'h0, 4'h0, k);
    check("t3_full",    64'(st_of(2)), 64'(st(1, 1, 1, 0, 8, 1)));
    drive(4'h4, 4'h0, 4'h0, 99);
    check("t3_rej_ovf", 64'(st_of(2)), 64'(st(1, 1, 1, 1, 8, 1)));
    check("t3_ow_ovf",  64'(st_ow(2)), 64'(st(1, 1, 1, 1, 8, 2)));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_rej_head%0d", k), 64'(D_pop[2]),    64'(k + 1));
      check($sformatf("t3_ow_head%0d", k),  64'(ow_D_pop[2]), 64'((k < 7) ? k + 2 : 99));
      drive(4'h0, 4'h4, 4'h0, 0);
    end
    check("t3_rej_empty", 64'(st_of(2)), 64'(st(0, 0, 0, 1, 0, 0)));
    check("t3_ow_empty",  64'(st_ow(2)), 64'(st(0, 0, 0, 1, 0, 0)));

    // Pointer wrap on ch0: steady occupancy of 3 with push+pop every cycle.
    for (int k = 0; k < 3; k++) drive(4'h1, 4'h0, 4'h0, 100 + k);
    for (int i = 0; i < 20; i++) begin
      drive(4'h1, 4'h1, 4'h0, 103 + i);
      check($sformatf("t6_wrap%0d", i), 64'(st_of(0)), 64'(st(1, 0, 0, 0, 3, 101 + i)));
    end

    // Re-arm ch3 overflow, then reset mid-stream with pushes still asserted.
    drive(4'h8, 4'h0, 4'h0, 7);
    check("t6_ovf_rearm", 64'(ovf[3]), 64'h1);
    @(negedge clk);
    reset = 1'b1; push = 4'hF; pop = 4'h0; clr_ovf = 4'h0; D_push = {4{16'h1234}};
    @(posedge clk);
    #1;
    check("mid_rst_dpop",      64'(D_pop), 64'h0);
    check("mid_rst_status",    64'({pndng, full, almost_full, ovf, count}), 64'h0);
    check("mid_rst_ow_dpop",   64'(ow_D_pop), 64'h0);
    check("mid_rst_ow_status", 64'({ow_pndng, ow_full, ow_almost_full, ow_ovf, ow_count}), 64'h0);
    @(negedge clk);
    reset = 1'b0; push = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
